// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with local misalignment errors
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_rsp_valid,
   output logic [31:0]       if_rsp_data,
   output logic              if_rsp_err,
   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic [ADDR_W-1:0] ls_req_addr,
   input  logic              ls_req_write,
   input  logic [31:0]       ls_req_wdata,
   input  logic [1:0]        ls_req_size,
   input  logic              ls_req_unsigned,
   output logic              ls_rsp_valid,
   output logic [31:0]       ls_rsp_rdata,
   output logic              ls_rsp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_write,
   output logic [31:0]       mem_req_wdata,
   output logic [3:0]        mem_req_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rsp_rdata,
   input  logic              mem_rsp_err
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LERR} state_t;
   state_t state, state_nx;
   logic [3:0] starve;
   logic own_ls, uns_q, ls_win, if_win, acc, mis, sg;
   logic [1:0] off, size_q, off_in;
   logic [ADDR_W-1:0] a_in;
   logic [31:0] wd, sh, ls_data;
   logic [3:0] sb;
   always_comb begin
      ls_win = ls_req_valid && !(if_req_valid && starve == 4'(STARVE_LIMIT));
      if_win = if_req_valid && !ls_win;
      ls_req_ready = rst_n && state == IDLE && ls_win;
      if_req_ready = rst_n && state == IDLE && if_win;
      acc = ls_req_ready || if_req_ready;
      a_in = ls_win ? ls_req_addr : if_req_addr;
      off_in = a_in[1:0];
      mis = ls_win ? (ls_req_size == 2'd3 || (ls_req_size == 2'd2 && off_in != 2'd0) ||
                      (ls_req_size == 2'd1 && off_in[0])) : off_in != 2'd0;
      state_nx = state == IDLE  ? (acc ? (mis ? LERR : ISSUE) : IDLE) :
                 state == ISSUE ? (mem_req_ready ? WAIT : ISSUE) :
                 state == WAIT  ? (mem_rsp_valid ? IDLE : WAIT) : IDLE;
      mem_req_valid = state == ISSUE;
      wd = ls_req_size == 2'd0 ? {4{ls_req_wdata[7:0]}} :
           ls_req_size == 2'd1 ? {2{ls_req_wdata[15:0]}} : ls_req_wdata;
      sb = !ls_req_write ? 4'b0000 : ls_req_size == 2'd0 ? 4'b0001 << off_in :
           ls_req_size == 2'd1 ? 4'b0011 << off_in : 4'b1111;
      sh = mem_rsp_rdata >> {off, 3'b000};
      sg = !uns_q && (size_q == 2'd0 ? sh[7] : sh[15]);
      ls_data = mem_req_write ? 32'd0 : size_q == 2'd0 ? {{24{sg}}, sh[7:0]} :
                size_q == 2'd1 ? {{16{sg}}, sh[15:0]} : sh;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         starve <= '0;
         own_ls <= 1'b0;
         uns_q <= 1'b0;
         off <= '0;
         size_q <= '0;
         mem_req_addr <= '0;
         mem_req_write <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_wstrb <= '0;
         if_rsp_valid <= 1'b0;
         if_rsp_data <= '0;
         if_rsp_err <= 1'b0;
         ls_rsp_valid <= 1'b0;
         ls_rsp_rdata <= '0;
         ls_rsp_err <= 1'b0;
      end else begin
         if_rsp_valid <= 1'b0;
         ls_rsp_valid <= 1'b0;
         if (!if_req_valid || if_req_ready) starve <= '0;
         else if (ls_req_ready) starve <= starve + 4'd1;
         if (acc) begin
            own_ls <= ls_win;
            uns_q <= ls_req_unsigned;
            off <= off_in;
            size_q <= ls_req_size;
            mem_req_addr <= {a_in[ADDR_W-1:2], 2'b00};
            mem_req_write <= ls_win && ls_req_write;
            mem_req_wdata <= ls_win ? wd : 32'd0;
            mem_req_wstrb <= ls_win ? sb : 4'd0;
         end
         // local errors reuse the response path with zero data
         if ((state == WAIT && mem_rsp_valid) || state == LERR) begin
            if (own_ls) begin
               ls_rsp_valid <= 1'b1;
               ls_rsp_err <= state == LERR || mem_rsp_err;
               ls_rsp_rdata <= state == LERR ? 32'd0 : ls_data;
            end else begin
               if_rsp_valid <= 1'b1;
               if_rsp_err <= state == LERR || mem_rsp_err;
               if_rsp_data <= state == LERR ? 32'd0 : mem_rsp_rdata;
            end
         end
      end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single memory port between instruction fetch (IF) and the load/store path (LS), which is driven by the decoder's mem_read/mem_write/mem_size/mem_unsigned.
- Arbitrates between the two requesters and keeps at most one transaction outstanding.
- Generates byte strobes and replicated store data.
- Aligns and sign- or zero-extends load data.
- Answers misaligned accesses locally with an error, without touching memory.

Parameters:
ADDR_W, 32, address width.
STARVE_LIMIT, 4, max consecutive LS grants while IF is waiting; range 1..15.

Ports:
clk  in  1  core clock
rst_n  in  1  reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  ADDR_W  fetch address
if_rsp_valid  out  1  fetch response, one-cycle pulse
if_rsp_data  out  32  instruction word
if_rsp_err  out  1  fetch fault
ls_req_valid  in  1  load/store request
ls_req_ready  out  1  LS request accepted this cycle
ls_req_addr  in  ADDR_W  byte address
ls_req_write  in  1  1=store, 0=load
ls_req_wdata  in  32  store data, LSB-aligned
ls_req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
ls_req_unsigned  in  1  zero-extend load
ls_rsp_valid  out  1  LS response, one-cycle pulse
ls_rsp_rdata  out  32  extended load data; 0 for stores
ls_rsp_err  out  1  misaligned/illegal access or memory error
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  word-aligned address ([1:0]=0)
mem_req_write  out  1  write
mem_req_wdata  out  32  replicated store data
mem_req_wstrb  out  4  byte enables
mem_rsp_valid  in  1  memory response
mem_rsp_rdata  in  32  read word
mem_rsp_err  in  1  bus error

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset state: all outputs 0, FSM=IDLE, starve counter=0.
- FSM states: IDLE, ISSUE, WAIT, LERR.
- IDLE, requester readiness:
  - *_req_ready is combinational and asserted only in IDLE, only to the winner.
  - The handshake completes when valid&&ready.
  - Request fields are registered on accept.
- IDLE, arbitration:
  - LS wins by default.
  - IF wins if ls_req_valid=0, or if if_req_valid=1 and starve==STARVE_LIMIT.
  - starve increments on each LS grant while if_req_valid=1.
  - starve clears on an IF grant or whenever if_req_valid=0.
- IDLE, alignment check on accept:
  - Misaligned means: size=1 with addr[0]=1; size=2 with addr[1:0]!=0; size=3; IF with addr[1:0]!=0.
  - Misaligned -> LERR. Aligned -> ISSUE.
- ISSUE:
  - mem_req_valid=1, with fields held stable, until mem_req_ready.
  - Then -> WAIT.
  - Earliest mem_req_valid is the cycle after accept.
- WAIT:
  - On mem_rsp_valid, the owner's rsp_valid pulses for exactly 1 cycle, registered (the cycle after mem_rsp_valid).
  - err=mem_rsp_err. Then -> IDLE.
  - Memory latency is unbounded; no timeout.
- LERR: owner's rsp_valid=1 and err=1 with data=0 for one cycle -> IDLE. No memory traffic.
- Responses have no backpressure.
- mem_rsp_valid outside WAIT is ignored. This includes a response for a transaction killed by reset.
- The next request may be accepted in the IDLE cycle in which the previous rsp_valid is asserted.
- Store formatting, with off=addr[1:0]:
  - Byte: wdata={4{wdata[7:0]}}, wstrb=4'b0001<<off.
  - Half: wdata={2{wdata[15:0]}}, wstrb=4'b0011<<off.
  - Word: wdata unchanged, wstrb=4'b1111.
- Loads and fetches: wstrb=0.
- Load formatting: sh=mem_rsp_rdata>>(8*off).
  - Byte: bits[7:0] extended.
  - Half: bits[15:0] extended.
  - Word: unchanged.
  - Extension is sign unless unsigned=1.
- Store response: rdata=0.
- IF response: data=mem_rsp_rdata unchanged.
- Simultaneous IF and LS valid: arbitration rule above.
- A request that is deasserted before ready is never issued.
- Reset mid-transaction: immediate IDLE, outputs 0, and the owner's response is never produced.

Test Plan:
- Load byte: LS load addr=0x103, size=0, unsigned=0; memory returns 0x80112233. Expect mem_req_addr=0x100, wstrb=0; one cycle after mem_rsp_valid, ls_rsp_rdata=0xFFFFFF80, err=0. Repeat with unsigned=1: expect 0x00000080.
- Store half: LS store addr=0x206, size=1, wdata=0x0000BEEF. Expect mem_req_wdata=0xBEEFBEEF, wstrb=4'b1100, addr=0x204, write=1; ls_rsp_valid one cycle after mem_rsp_valid with rdata=0.
- Misaligned word: LS word load at addr=0x101. Expect mem_req_valid never asserted; ls_rsp_valid=1, err=1, rdata=0 on the second cycle after accept. Repeat with size=3: same result.
- Starvation limit: IF and LS valid continuously, STARVE_LIMIT=4, 1-cycle memory. Expect grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF,...
- Memory stall: mem_req_ready held low for 5 cycles. Expect mem_req_* stable throughout, no new *_req_ready; a stray mem_rsp_valid during ISSUE is ignored.
- Reset mid-transaction: rst_n low in WAIT. Expect all outputs 0 asynchronously; a later mem_rsp_valid produces no rsp pulse, and the next IF request is served normally.
